// File: rtl/pio_poll_master.sv
// pio_poll_master: polls a 1-bit PIO responder over Avalon-MM and tracks its level.
// Optional debounce of accepted changes: define PIO_POLL_DEBOUNCE_EN.
module pio_poll_master #(
  parameter int POLL_PERIOD      = 1000,
  parameter int POLL_ADDR        = 0,
  parameter int ADDR_W           = 2,
  parameter int DEBOUNCE_SAMPLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              level,
  output logic              level_valid,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [15:0]       edge_count,
  output logic              overrun
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tick;
  logic            drop;
  logic            sample;
  logic            accept;
  logic            level_q, level_d;
  logic            valid_q, valid_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [15:0]     count_q, count_d;
  logic            ovr_q, ovr_d;
  logic            unused_ok;

`ifdef PIO_POLL_DEBOUNCE_EN
  localparam int MW = $clog2(DEBOUNCE_SAMPLES + 1);
  logic            cand_q, cand_d;
  logic [MW-1:0]   match_q, match_d;
  assign unused_ok = ^avm_readdata[31:1];
`else
  assign unused_ok = ^{avm_readdata[31:1], DEBOUNCE_SAMPLES != 0};
`endif

  assign avm_address = ADDR_W'(POLL_ADDR);
  assign level       = level_q;
  assign level_valid = valid_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign edge_count  = count_q;
  assign overrun     = ovr_q;
  assign sample      = avm_readdata[0];

  // period timer: counts down while enabled, ticks on reload
  always_comb begin
    timer_d = RELOAD;
    tick    = 1'b0;
    if (enable) begin
      if (timer_q == '0) begin
        tick = 1'b1;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  // poll FSM: launch on tick, hold read through stalls, capture once
  always_comb begin
    state_d  = state_q;
    avm_read = 1'b0;
    unique case (state_q)
      IDLE: if (tick) state_d = REQ;
      REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_d = CAP;
      end
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign drop = tick && (state_q != IDLE);

  // sample update: level, pulses, saturating count, sticky overrun
  always_comb begin
    level_d = level_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    ovr_d   = ovr_q;
    accept  = 1'b0;
`ifdef PIO_POLL_DEBOUNCE_EN
    cand_d  = cand_q;
    match_d = match_q;
`endif
    if (state_q == CAP) begin
      if (!valid_q) begin
        level_d = sample;
        valid_d = 1'b1;
      end else if (sample != level_q) begin
`ifdef PIO_POLL_DEBOUNCE_EN
        if (match_q != '0 && cand_q == sample) begin
          match_d = match_q + MW'(1);
        end else begin
          cand_d  = sample;
          match_d = MW'(1);
        end
        if (match_d == MW'(DEBOUNCE_SAMPLES)) begin
          accept  = 1'b1;
          match_d = '0;
        end
`else
        accept = 1'b1;
`endif
      end
`ifdef PIO_POLL_DEBOUNCE_EN
      else begin
        match_d = '0;
      end
`endif
    end
    if (accept) begin
      level_d = sample;
      rise_d  = sample;
      fall_d  = !sample;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
    if (drop) ovr_d = 1'b1;
    if (clear_count) begin
      count_d = '0;
      ovr_d   = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= RELOAD;
      level_q <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef PIO_POLL_DEBOUNCE_EN
  // debounce candidate and match counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q  <= 1'b0;
      match_q <= '0;
    end else begin
      cand_q  <= cand_d;
      match_q <= match_d;
    end
  end
`endif

endmodule
